// File: rtl/relobi_a_other_enc_reg.sv
// Registered relOBI A-channel encoder: Hsiao check bits over {we, be, aid, a_optional}, one-entry buffer.
// Latency 1 cycle from upstream handshake to req_o; gnt_o = !full | gnt_i gives one transfer per cycle.
// Optional stored-codeword self-check (sticky err_o) is built only with RELOBI_A_OTHER_ENC_SELFCHECK_EN.

package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
        int unsigned AOptionalWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32, DataWidth: 32, IdWidth: 1, AOptionalWidth: 1
    };
endpackage

package relobi_pkg;
    function automatic int unsigned relobi_a_other_width(obi_pkg::obi_cfg_t cfg);
        return 1 + cfg.DataWidth / 8 + cfg.IdWidth + cfg.AOptionalWidth;
    endfunction

    // Smallest r with 2^(r-1) >= k + r, i.e. SECDED for k data bits.
    function automatic int unsigned hsiao_ecc_width(int unsigned k);
        int unsigned r;
        r = 2;
        while ((32'd1 << (r - 1)) < (k + r)) r++;
        return r;
    endfunction

    function automatic int unsigned relobi_a_other_ecc_width(obi_pkg::obi_cfg_t cfg);
        return hsiao_ecc_width(relobi_a_other_width(cfg));
    endfunction

    // Column idx of the Hsiao matrix: odd-weight (>=3) vectors by ascending weight, then value.
    function automatic int unsigned hsiao_col(int unsigned r, int unsigned idx);
        int unsigned cnt;
        int unsigned res;
        cnt = 0;
        res = 0;
        for (int unsigned w = 3; w <= r; w += 2) begin
            for (int unsigned v = 0; v < (32'd1 << r); v++) begin
                if ($countones(v) == w) begin
                    if (cnt == idx) res = v;
                    cnt++;
                end
            end
        end
        return res;
    endfunction
endpackage

module hsiao_ecc_enc #(
    parameter int unsigned DataWidth  = 7,
    parameter int unsigned ProtWidth  = relobi_pkg::hsiao_ecc_width(DataWidth),
    parameter int unsigned TotalWidth = DataWidth + ProtWidth
) (
    input  logic [DataWidth-1:0]  data_i,
    output logic [TotalWidth-1:0] code_o
);
    logic [ProtWidth-1:0] contrib [DataWidth];
    logic [ProtWidth-1:0] ecc;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam int unsigned Col = relobi_pkg::hsiao_col(ProtWidth, i);
        assign contrib[i] = data_i[i] ? Col[ProtWidth-1:0] : '0;
    end

    always_comb begin
        ecc = '0;
        for (int unsigned i = 0; i < DataWidth; i++) ecc ^= contrib[i];
    end

    assign code_o = {ecc, data_i};
endmodule

`ifdef RELOBI_A_OTHER_ENC_SELFCHECK_EN
module hsiao_ecc_dec #(
    parameter int unsigned DataWidth  = 7,
    parameter int unsigned ProtWidth  = relobi_pkg::hsiao_ecc_width(DataWidth),
    parameter int unsigned TotalWidth = DataWidth + ProtWidth
) (
    input  logic [TotalWidth-1:0] code_i,
    output logic                  err_o
);
    logic [TotalWidth-1:0] recode;

    hsiao_ecc_enc #(
        .DataWidth (DataWidth),
        .ProtWidth (ProtWidth),
        .TotalWidth(TotalWidth)
    ) i_enc (
        .data_i(code_i[DataWidth-1:0]),
        .code_o(recode)
    );

    assign err_o = |(recode[TotalWidth-1:DataWidth] ^ code_i[TotalWidth-1:DataWidth]);
endmodule
`endif

module relobi_a_other_enc_reg #(
    parameter obi_pkg::obi_cfg_t Cfg           = obi_pkg::ObiDefaultConfig,
    parameter type               a_optional_t  = logic,
    parameter int unsigned       OtherEccWidth = relobi_pkg::relobi_a_other_ecc_width(Cfg)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic                       we_i,
    input  logic [Cfg.DataWidth/8-1:0] be_i,
    input  logic [Cfg.IdWidth-1:0]     aid_i,
    input  a_optional_t                a_optional_i,
    output logic                       req_o,
    input  logic                       gnt_i,
    output logic                       we_o,
    output logic [Cfg.DataWidth/8-1:0] be_o,
    output logic [Cfg.IdWidth-1:0]     aid_o,
    output a_optional_t                a_optional_o,
    output logic [OtherEccWidth-1:0]   other_ecc_o,
    output logic                       err_o
);
    localparam int unsigned OtherWidth = relobi_pkg::relobi_a_other_width(Cfg);
    localparam int unsigned CodeWidth  = OtherWidth + OtherEccWidth;

    logic [OtherWidth-1:0] data_in;
    logic [CodeWidth-1:0]  code_in, code_d, code_q;
    logic                  full_d, full_q, capture;

    assign data_in = {we_i, be_i, aid_i, a_optional_i};

    hsiao_ecc_enc #(
        .DataWidth (OtherWidth),
        .ProtWidth (OtherEccWidth),
        .TotalWidth(CodeWidth)
    ) i_enc (
        .data_i(data_in),
        .code_o(code_in)
    );

    assign gnt_o   = ~full_q | gnt_i;
    assign capture = req_i & gnt_o;

    always_comb begin
        full_d = full_q;
        code_d = code_q;
        if (capture) begin
            full_d = 1'b1;
            code_d = code_in;
        end else if (gnt_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            code_q <= '0;
        end else begin
            full_q <= full_d;
            code_q <= code_d;
        end
    end

    // Gating by rst_i keeps a buffered entry from handshaking while reset is asserted.
    assign req_o = full_q & ~rst_i;
    assign {other_ecc_o, we_o, be_o, aid_o, a_optional_o} = rst_i ? '0 : code_q;

`ifdef RELOBI_A_OTHER_ENC_SELFCHECK_EN
    logic err_d, err_q, syn_err;

    hsiao_ecc_dec #(
        .DataWidth (OtherWidth),
        .ProtWidth (OtherEccWidth),
        .TotalWidth(CodeWidth)
    ) i_dec (
        .code_i(code_q),
        .err_o (syn_err)
    );

    assign err_d = err_q | (full_q & syn_err);

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q & ~rst_i;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_relobi_a_other_enc_reg.sv
// Scoreboard bench for relobi_a_other_enc_reg (DataWidth=32, IdWidth=1, a_optional_t=logic).
// Driver pushes accepted requests into a queue; a negedge monitor pops and compares downstream handshakes.
module tb_relobi_a_other_enc_reg;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_i = 1'b0;
    logic       gnt_o;
    logic       we_i = 1'b0;
    logic [3:0] be_i = '0;
    logic [0:0] aid_i = '0;
    logic       a_optional_i = 1'b0;
    logic       req_o;
    logic       gnt_i = 1'b0;
    logic       we_o;
    logic [3:0] be_o;
    logic [0:0] aid_o;
    logic       a_optional_o;
    logic [4:0] other_ecc_o;
    logic       err_o;

    relobi_a_other_enc_reg dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .be_i        (be_i),
        .aid_i       (aid_i),
        .a_optional_i(a_optional_i),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .we_o        (we_o),
        .be_o        (be_o),
        .aid_o       (aid_o),
        .a_optional_o(a_optional_o),
        .other_ecc_o (other_ecc_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // SECDED Hsiao columns for 7 data bits / 5 check bits: weight-3 vectors in ascending order.
    localparam logic [4:0] HCOL [7] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110,
                                        5'b10011, 5'b10101, 5'b10110};

    int         ntests = 0;
    int         nfail  = 0;
    int         hs_cnt = 0;
    logic       mon_en = 1'b1;
    logic       model_full = 1'b0;
    logic       model_full_nxt = 1'b0;
    logic [6:0] exp_q [$];

    function automatic logic [4:0] ref_ecc(input logic [6:0] d);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 7; i++) if (d[i]) p = p ^ HCOL[i];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance from its own occupancy view.
    task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic a,
                         input logic o, input logic g, input logic rs);
        logic acc;
        @(posedge clk);
        #1;
        model_full   = model_full_nxt;
        req_i        = r;
        we_i         = w;
        be_i         = b;
        aid_i        = a;
        a_optional_i = o;
        gnt_i        = g;
        rst_i        = rs;
        if (rs) begin
            exp_q.delete();
            model_full_nxt = 1'b0;
        end else begin
            acc = r && (!model_full || g);
            if (acc) exp_q.push_back({w, b, a, o});
            model_full_nxt = acc || (model_full && !g);
        end
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, g, 1'b0);
    endtask

    task automatic drive_rand(input logic g);
        logic [31:0] rnd;
        rnd = $urandom;
        drive(1'b1, rnd[0], rnd[4:1], rnd[5], rnd[6], g, 1'b0);
    endtask

    initial begin : monitor
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_i) begin
                    chk("rst_req_o", 64'(req_o), 64'(0));
                    chk("rst_fields", 64'({other_ecc_o, we_o, be_o, aid_o, a_optional_o}), 64'(0));
                    chk("rst_err_o", 64'(err_o), 64'(0));
                end else begin
                    chk("gnt_o", 64'(gnt_o), 64'(!model_full || gnt_i));
                    chk("req_o", 64'(req_o), 64'(model_full));
                    chk("err_o", 64'(err_o), 64'(0));
                    if (req_o) begin
                        chk("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q[0];
                            chk("fields", 64'({we_o, be_o, aid_o, a_optional_o}), 64'(e));
                            chk("ecc", 64'(other_ecc_o), 64'(ref_ecc(e)));
                            if (gnt_i) begin
                                void'(exp_q.pop_front());
                                hs_cnt++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int hs0;
`ifdef RELOBI_A_OTHER_ENC_SELFCHECK_EN
        logic [11:0] cw;
`endif
        repeat (3) drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Single transfer
        hs0 = hs_cnt;
        drive(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk); #1;
        chk("single_hs", 64'(hs_cnt - hs0), 64'(1));

        // Back-pressure: held five cycles, then exactly one handshake
        hs0 = hs_cnt;
        drive(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        @(negedge clk); #1;
        chk("bp_held_hs", 64'(hs_cnt - hs0), 64'(0));
        idle(1'b1);
        idle(1'b0);
        @(negedge clk); #1;
        chk("bp_release_hs", 64'(hs_cnt - hs0), 64'(1));
        chk("bp_empty_q", 64'(exp_q.size()), 64'(0));

        // Streaming: 16 back-to-back with gnt_i held high
        idle(1'b1);
        hs0 = hs_cnt;
        for (int i = 0; i < 16; i++) drive_rand(1'b1);
        idle(1'b1);
        @(negedge clk); #1;
        chk("stream_hs", 64'(hs_cnt - hs0), 64'(16));

        // Reset while full and stalled: entry must vanish
        hs0 = hs_cnt;
        drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk); #1;
        chk("rst_drop_hs", 64'(hs_cnt - hs0), 64'(0));

        // Randomized traffic with random downstream grant
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rnd;
            rnd = $urandom;
            if (rnd[8]) drive_rand(rnd[10:9] != 2'b00);
            else        idle(rnd[10:9] != 2'b00);
        end
        repeat (3) idle(1'b1);
        @(negedge clk); #1;
        chk("drain_q", 64'(exp_q.size()), 64'(0));

`ifdef RELOBI_A_OTHER_ENC_SELFCHECK_EN
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        mon_en = 1'b0;
        cw = dut.code_q;
        force dut.code_q = cw ^ 12'h001;
        @(posedge clk); #1;
        chk("selfcheck_err_set", 64'(err_o), 64'(1));
        release dut.code_q;
        repeat (3) @(posedge clk);
        #1;
        chk("selfcheck_err_sticky", 64'(err_o), 64'(1));
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk); #1;
        chk("selfcheck_err_cleared", 64'(err_o), 64'(0));
`else
        chk("err_o_tied_low", 64'(err_o), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/relobi_a_other_enc_reg.md
RELOBI_A_OTHER_ENC_REG -- requirements
Module: relobi_a_other_enc_reg

Interface
REQ-001 SHALL have parameter Cfg, default obi_pkg::ObiDefaultConfig, meaning the OBI bus configuration.
REQ-002 SHALL have parameter a_optional_t, default logic, meaning the A-channel optional-field type.
REQ-003 SHALL have parameter OtherEccWidth, default relobi_pkg::relobi_a_other_ecc_width(Cfg), meaning the number of Hsiao check bits.
REQ-004 SHALL have port clk_i, input, 1 bit, the clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port req_i, input, 1 bit, upstream A request.
REQ-007 SHALL have port gnt_o, output, 1 bit, upstream grant.
REQ-008 SHALL have ports we_i (1 bit), be_i (Cfg.DataWidth/8 bits), aid_i (Cfg.IdWidth bits) and a_optional_i (a_optional_t), all inputs carrying the unprotected fields.
REQ-009 SHALL have port req_o, output, 1 bit, downstream A request.
REQ-010 SHALL have port gnt_i, input, 1 bit, downstream grant.
REQ-011 SHALL have ports we_o, be_o, aid_o, a_optional_o, outputs with the same widths as the inputs, carrying the registered fields.
REQ-012 SHALL have port other_ecc_o, output, OtherEccWidth bits, check bits over the registered fields.
REQ-013 SHALL have port err_o, output, 1 bit, sticky self-check fault flag.

Function
REQ-014 SHALL encode with hsiao_ecc_enc, DataWidth relobi_pkg::relobi_a_other_width(Cfg), data ordered {we, be, aid, a_optional}, MSB first.
REQ-015 SHALL present the codeword as {other_ecc_o, we_o, be_o, aid_o, a_optional_o}, so that relobi_a_other_decoder accepts it unchanged.
REQ-016 SHALL compute ECC combinationally from the inputs and register codeword and fields together in a one-entry buffer tracked by a full flag.
REQ-017 SHALL drive gnt_o = !full | gnt_i.
REQ-018 SHALL drive req_o = full.
REQ-019 SHALL, on req_i & gnt_o, capture the inputs and set full; latency from input handshake to req_o high is exactly 1 cycle.
REQ-020 SHALL, on req_o & gnt_i with no simultaneous capture, clear full.
REQ-021 SHALL, on simultaneous downstream handshake and upstream capture, replace the entry and keep full high, giving 1 transfer per cycle.
REQ-022 SHALL hold all outputs stable while req_o=1 and gnt_i=0, as OBI requires.
REQ-023 SHALL not load the buffer when req_i=0, regardless of field values.

Reset
REQ-024 SHALL, while rst_i is high, clear full.
REQ-025 SHALL, while rst_i is high, drive req_o=0, we_o=0, be_o=0, aid_o=0, a_optional_o='0, other_ecc_o=0 and err_o=0.
REQ-026 SHALL, when rst_i asserts mid-transfer, discard the buffered entry without issuing a handshake.
REQ-027 SHALL drive gnt_o=1 in the first cycle after reset.

Configuration
REQ-028 SHALL, with RELOBI_A_OTHER_ENC_SELFCHECK_EN defined, decode the stored codeword each cycle with hsiao_ecc_dec while full, and set err_o on a nonzero syndrome.
REQ-029 SHALL keep err_o set once raised, until reset.
REQ-030 SHALL, with RELOBI_A_OTHER_ENC_SELFCHECK_EN undefined, contain no decoder and tie err_o to 0.

Verification (Cfg DataWidth=32, IdWidth=1, a_optional_t=logic)
REQ-031 SHALL cover a single transfer: req_i=1, we=1, be=4'hF, aid=1, gnt_i=1 -> req_o high the next cycle, and decoding the codeword yields we=1, be=4'hF, aid=1 with zero syndrome.
REQ-032 SHALL cover back-pressure: gnt_i=0 for 5 cycles after capture -> gnt_o=0 and outputs constant for 5 cycles; gnt_i=1 -> one handshake, full clears.
REQ-033 SHALL cover streaming: 16 back-to-back requests with gnt_i=1 -> 16 downstream handshakes in 17 cycles, in order, with correct ECC.
REQ-034 SHALL cover reset mid-operation: rst_i pulsed while full and gnt_i=0 -> req_o=0 the next cycle, and the entry is never delivered.
REQ-035 SHALL cover self-check (macro defined): force one stored bit flipped -> err_o=1 the next cycle and staying 1 until rst_i; with the macro undefined, err_o stays 0.
